// File: rtl/spi_pkg.sv
// Shared types and constants for the multi-chip-select SPI master.
package spi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCsSetup,
        StShift,
        StWaitWord,
        StCsHold,
        StCsInactive
    } spi_state_e;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    localparam int unsigned CPOL_BIT = 1;
    localparam int unsigned CPHA_BIT = 0;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK divider: while run is high, toggles SCLK every HALF_BIT_CLKS clocks and strobes
// leading/trailing edges; done marks the last edge of a word. Idles at cpol otherwise.
module spi_clk_gen #(
    parameter int unsigned HALF_BIT_CLKS = 2,
    parameter int unsigned WORD_BITS     = 8
) (
    input  logic i_FPGA_clk,
    input  logic i_FPGA_rst,
    input  logic run,
    input  logic cpol,
    output logic sclk,
    output logic lead,
    output logic trail,
    output logic done
);

    localparam int unsigned DW = $clog2(HALF_BIT_CLKS) + 1;
    localparam int unsigned EW = $clog2(2 * WORD_BITS);

    logic [DW-1:0] div_q;
    logic [EW-1:0] edge_cnt_q;
    logic          sclk_q;
    logic          tick;

    assign tick  = run && (div_q == DW'(HALF_BIT_CLKS - 1));
    assign lead  = tick && !edge_cnt_q[0];
    assign trail = tick && edge_cnt_q[0];
    assign done  = trail && (edge_cnt_q == EW'(2 * WORD_BITS - 1));
    assign sclk  = sclk_q;

    // Counters sit at zero whenever run is low, so every word starts with a fresh divider.
    always_ff @(posedge i_FPGA_clk or negedge i_FPGA_rst) begin
        if (!i_FPGA_rst) begin
            div_q      <= '0;
            edge_cnt_q <= '0;
            sclk_q     <= 1'b0;
        end else if (!run) begin
            div_q      <= '0;
            edge_cnt_q <= '0;
            sclk_q     <= cpol;
        end else if (tick) begin
            div_q      <= '0;
            edge_cnt_q <= edge_cnt_q + EW'(1);
            sclk_q     <= ~sclk_q;
        end else begin
            div_q <= div_q + DW'(1);
        end
    end

endmodule

// File: rtl/spi_master_multi_cs.sv
// SPI master with per-transaction mode and chip select; a multi-word transaction runs
// under a single CS assertion with programmable setup, hold and inactive timing.
module spi_master_multi_cs
    import spi_pkg::*;
#(
    parameter int unsigned WORD_BITS        = 8,
    parameter int unsigned NUM_CS           = 2,
    parameter int unsigned MAX_WORDS        = 16,
    parameter int unsigned HALF_BIT_CLKS    = 2,
    parameter int unsigned CS_SETUP_CLKS    = 1,
    parameter int unsigned CS_HOLD_CLKS     = 1,
    parameter int unsigned CS_INACTIVE_CLKS = 2,
    localparam int unsigned CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
    localparam int unsigned CW  = $clog2(MAX_WORDS + 1)
) (
    input  logic                 i_FPGA_clk,
    input  logic                 i_FPGA_rst,
    input  logic [CSW-1:0]       i_cs_sel,
    input  logic [1:0]           i_mode,
    input  logic [CW-1:0]        i_word_count,
    input  logic [WORD_BITS-1:0] i_MOSI,
    input  logic                 i_MOSIdv,
    output logic                 o_MOSI_ready,
    output logic [WORD_BITS-1:0] o_MISO,
    output logic                 o_MISOdv,
    output logic [CW-1:0]        o_MISO_count,
    output logic                 o_busy,
    output logic                 o_SPI_clk,
    input  logic                 i_SPI_MISO,
    output logic                 o_SPI_MOSI,
    output logic [NUM_CS-1:0]    o_SPI_CS_n
);

    localparam int unsigned BW = $clog2(WORD_BITS);

    spi_state_e           state_q, state_d;
    logic [15:0]          tmr_q;
    logic [1:0]           mode_q;
    logic [WORD_BITS-1:0] tx_q, rx_q, rx_nxt;
    logic [BW-1:0]        bit_q, bit_nxt;
    logic [CW-1:0]        left_q, cnt_sat;
    logic [NUM_CS-1:0]    cs_dec;
    logic accept, first, accept_cpha, cpha, sclk_cpol, tmr_zero;
    logic lead, trail, done, sample, drive;

    assign accept      = i_MOSIdv && o_MOSI_ready;
    assign first       = accept && (state_q == StIdle);
    assign accept_cpha = (state_q == StIdle) ? i_mode[CPHA_BIT] : mode_q[CPHA_BIT];
    assign cpha        = mode_q[CPHA_BIT];
    assign sclk_cpol   = first ? i_mode[CPOL_BIT] : mode_q[CPOL_BIT];
    assign sample      = cpha ? trail : lead;
    assign drive       = cpha ? lead : trail;
    assign tmr_zero    = (tmr_q == '0);
    assign bit_nxt     = bit_q - BW'(1);
    assign rx_nxt      = {rx_q[WORD_BITS-2:0], i_SPI_MISO};

    spi_clk_gen #(
        .HALF_BIT_CLKS (HALF_BIT_CLKS),
        .WORD_BITS     (WORD_BITS)
    ) u_clk_gen (
        .i_FPGA_clk (i_FPGA_clk),
        .i_FPGA_rst (i_FPGA_rst),
        .run        (state_q == StShift),
        .cpol       (sclk_cpol),
        .sclk       (o_SPI_clk),
        .lead       (lead),
        .trail      (trail),
        .done       (done)
    );

    always_comb begin
        cnt_sat = i_word_count;
        if (i_word_count == '0) begin
            cnt_sat = CW'(1);
        end else if (i_word_count > CW'(MAX_WORDS)) begin
            cnt_sat = CW'(MAX_WORDS);
        end
        // Out-of-range selects leave every line deasserted; the transfer still runs.
        cs_dec = '1;
        if (32'(i_cs_sel) < NUM_CS) begin
            cs_dec[i_cs_sel] = 1'b0;
        end
        state_d = state_q;
        unique case (state_q)
            StIdle:       if (accept)   state_d = StCsSetup;
            StCsSetup:    if (tmr_zero) state_d = StShift;
            StShift:      if (done)     state_d = (left_q == '0) ? StCsHold : StWaitWord;
            StWaitWord:   if (accept)   state_d = StShift;
            StCsHold:     if (tmr_zero) state_d = StCsInactive;
            StCsInactive: if (tmr_zero) state_d = StIdle;
            default:                    state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_FPGA_clk or negedge i_FPGA_rst) begin
        if (!i_FPGA_rst) begin
            state_q      <= StIdle;
            tmr_q        <= '0;
            mode_q       <= '0;
            tx_q         <= '0;
            rx_q         <= '0;
            bit_q        <= '0;
            left_q       <= '0;
            o_SPI_CS_n   <= '1;
            o_SPI_MOSI   <= 1'b0;
            o_MISO       <= '0;
            o_MISOdv     <= 1'b0;
            o_MISO_count <= '0;
            o_busy       <= 1'b0;
            o_MOSI_ready <= 1'b0;
        end else begin
            state_q      <= state_d;
            o_MOSI_ready <= (state_d == StIdle) || (state_d == StWaitWord);
            o_busy       <= (state_d != StIdle);
            o_MISOdv     <= 1'b0;

            if (state_d != state_q) begin
                case (state_d)
                    StCsSetup:    tmr_q <= 16'(CS_SETUP_CLKS - 1);
                    StCsHold:     tmr_q <= 16'(CS_HOLD_CLKS - 1);
                    StCsInactive: tmr_q <= 16'(CS_INACTIVE_CLKS - 1);
                    default:      tmr_q <= '0;
                endcase
            end else if (!tmr_zero) begin
                tmr_q <= tmr_q - 16'd1;
            end

            if (accept) begin
                tx_q  <= i_MOSI;
                bit_q <= BW'(WORD_BITS - 1);
                // CPHA=0 needs the MSB on the line before the first leading edge.
                if (!accept_cpha) begin
                    o_SPI_MOSI <= i_MOSI[WORD_BITS-1];
                end
            end

            if (first) begin
                mode_q       <= i_mode;
                left_q       <= cnt_sat - CW'(1);
                o_MISO_count <= '0;
                o_SPI_CS_n   <= cs_dec;
            end else if (accept) begin
                left_q <= left_q - CW'(1);
            end

            if (drive && cpha) begin
                o_SPI_MOSI <= tx_q[bit_q];
            end
            if (trail && (bit_q != '0)) begin
                bit_q <= bit_nxt;
                if (!cpha) begin
                    o_SPI_MOSI <= tx_q[bit_nxt];
                end
            end

            if (sample) begin
                rx_q <= rx_nxt;
                if (bit_q == '0) begin
                    o_MISO       <= rx_nxt;
                    o_MISOdv     <= 1'b1;
                    o_MISO_count <= o_MISO_count + CW'(1);
                end
            end

            if ((state_q == StCsHold) && tmr_zero) begin
                o_SPI_CS_n <= '1;
            end
        end
    end

endmodule
